lsu_data_mem: RTL and testbench

- Data-memory responder for the core's LSU read and write ports. It is the target end of the LSU load/store protocol.
- Read port: level request with a one-cycle ack pulse and configurable latency.
- Write port: single-cycle, byte-enabled, no ack.
- Sits between the LSU (and its alignment unit) and a word-organised on-chip RAM. Backs all data loads and stores of the core.

---
 rtl/lsu_mem_pkg.sv | 14 +
 rtl/lsu_data_mem_if.sv | 28 ++
 rtl/bram_be.sv | 41 ++++
 rtl/lsu_data_mem.sv | 105 ++++++++++
 tb/tb_lsu_data_mem.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared types and constants for the LSU data-memory responder.
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    HOLD
  } lsu_mem_state_e;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/lsu_data_mem_if.sv
// LSU read/write port bundle; master is the LSU, slave is the data memory.
interface lsu_data_mem_if
  import lsu_mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic                  lsu_read;
  logic [AW-1:0]         r_lsu_addr;
  logic [DW-1:0]         r_lsu_data;
  logic                  lsu_ack;
  logic                  lsu_write;
  logic [AW-1:0]         w_lsu_addr;
  logic [BYTE_LANES-1:0] w_lsu_byte_en;
  logic [DW-1:0]         w_lsu_data;

  modport master (
    output lsu_read, r_lsu_addr, lsu_write, w_lsu_addr, w_lsu_byte_en, w_lsu_data,
    input  r_lsu_data, lsu_ack
  );

  modport slave (
    input  lsu_read, r_lsu_addr, lsu_write, w_lsu_addr, w_lsu_byte_en, w_lsu_data,
    output r_lsu_data, lsu_ack
  );

endinterface

// File: rtl/bram_be.sv
// Single-clock word RAM with byte-enabled write and registered, read-before-write read port.
module bram_be
  import lsu_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  localparam int unsigned IW       = $clog2(DEPTH),
  localparam int unsigned DW       = 8 * BYTE_LANES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_re,
  input  logic [IW-1:0]         i_raddr,
  output logic [DW-1:0]         o_rdata,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_waddr,
  input  logic [BYTE_LANES-1:0] i_be,
  input  logic [DW-1:0]         i_wdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < BYTE_LANES; b++) begin
        if (i_be[b]) mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_en && i_re) begin
      o_rdata <= mem[i_raddr];
    end
  end

endmodule

// File: rtl/lsu_data_mem.sv
// LSU data-memory responder: read-request FSM with configurable latency in front of bram_be.
module lsu_data_mem
  import lsu_mem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clk_en,
  lsu_data_mem_if.slave  bus,
  output logic           o_busy
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("lsu_data_mem: READ_LATENCY must be within 1..8");
  end
  if (DW != 8 * BYTE_LANES) begin : g_bad_width
    $error("lsu_data_mem: DW must be 32");
  end

  lsu_mem_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    r_idx, raddr;
  logic             re;

  assign r_idx = bus.r_lsu_addr[IW+1:2];

  logic unused_addr;
  assign unused_addr = ^{bus.r_lsu_addr[AW-1:IW+2], bus.r_lsu_addr[1:0],
                         bus.w_lsu_addr[AW-1:IW+2], bus.w_lsu_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    re      = 1'b0;
    raddr   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.lsu_read) begin
          idx_d = r_idx;
          if (READ_LATENCY == 1) begin
            re      = 1'b1;
            raddr   = r_idx;
            state_d = ACK;
          end else begin
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end
        end
      end
      // Address and read level are ignored here: the request is already committed.
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          re      = 1'b1;
          state_d = ACK;
        end
      end
      ACK:  state_d = bus.lsu_read ? HOLD : IDLE;
      HOLD: if (!bus.lsu_read) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.lsu_ack = (state_q == ACK);
  assign o_busy      = (state_q != IDLE);

  bram_be #(
    .DEPTH     (DEPTH_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_clk_en),
    .i_re    (re),
    .i_raddr (raddr),
    .o_rdata (bus.r_lsu_data),
    .i_we    (bus.lsu_write),
    .i_waddr (bus.w_lsu_addr[IW+1:2]),
    .i_be    (bus.w_lsu_byte_en),
    .i_wdata (bus.w_lsu_data)
  );

endmodule

// File: tb/tb_lsu_data_mem.sv
// Randomised self-checking bench: two responders (latency 1 and 3) against a transaction-level model.
module tb_lsu_data_mem;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        en    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ack   [2];
  logic        busy  [2];
  logic [31:0] rdat  [2];

  logic [31:0] mem_m [2][DEPTH];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  lsu_data_mem_if #(.AW(32), .DW(32)) bus0 ();
  lsu_data_mem_if #(.AW(32), .DW(32)) bus1 ();

  assign bus0.lsu_read      = rd[0];
  assign bus0.r_lsu_addr    = raddr[0];
  assign bus0.lsu_write     = wr[0];
  assign bus0.w_lsu_addr    = waddr[0];
  assign bus0.w_lsu_byte_en = be[0];
  assign bus0.w_lsu_data    = wdata[0];
  assign ack[0]             = bus0.lsu_ack;
  assign rdat[0]            = bus0.r_lsu_data;

  assign bus1.lsu_read      = rd[1];
  assign bus1.r_lsu_addr    = raddr[1];
  assign bus1.lsu_write     = wr[1];
  assign bus1.w_lsu_addr    = waddr[1];
  assign bus1.w_lsu_byte_en = be[1];
  assign bus1.w_lsu_data    = wdata[1];
  assign ack[1]             = bus1.lsu_ack;
  assign rdat[1]            = bus1.r_lsu_data;

  lsu_data_mem #(.READ_LATENCY(1)) u_dut0 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clk_en (en[0]),
    .bus      (bus0),
    .o_busy   (busy[0])
  );

  lsu_data_mem #(.READ_LATENCY(3)) u_dut1 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clk_en (en[1]),
    .bus      (bus1),
    .o_busy   (busy[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  // Word indices used by the bench; every one is initialised before any random read.
  function automatic int unsigned set_idx(input int k);
    return (k == 16) ? 16 : k * 64;
  endfunction

  function automatic logic [31:0] rnd_addr(input int unsigned idx);
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F000) | (idx << 2) | (r & 32'h3);
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a, input logic [3:0] b,
                                      input logic [31:0] v);
    for (int l = 0; l < 4; l++) begin
      if (b[l]) mem_m[d][widx(a)][8*l +: 8] = v[8*l +: 8];
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wr_word(input int d, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] v);
    en[d] = 1'b1; wr[d] = 1'b1; waddr[d] = a; be[d] = b; wdata[d] = v;
    @(posedge clk);
    model_write(d, a, b, v);
    #1;
    wr[d] = 1'b0;
  endtask

  // One read transaction: ack must come on the L-th enabled edge after acceptance, carrying the
  // word as it was before that edge's write; busy until an enabled edge after ack sees read low.
  task automatic do_read(input int d, input logic [31:0] a, input bit rnd, input bit coll,
                         input bit early, output logic [31:0] got);
    int          lat, n, hold;
    bit          done, e, w;
    logic [31:0] exp_d, wa, wv;
    logic [3:0]  wb;
    lat   = lat_of(d);
    n     = 0;
    done  = 1'b0;
    hold  = $urandom_range(2, 0);
    exp_d = '0;
    got   = '0;
    raddr[d] = a;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      e  = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      w  = rnd ? $urandom_range(1, 0) : 1'b0;
      wa = rnd_addr(set_idx($urandom_range(16, 0)));
      wb = 4'($urandom);
      wv = $urandom;
      if (coll && n == lat - 1) begin
        w = 1'b1; wa = a; wb = 4'hF; wv = 32'h2222_2222;
      end
      if (n < lat)       rd[d] = (n == 0) ? 1'b1 : !early;
      else if (n == lat) rd[d] = !early;
      else               rd[d] = ((n - lat) < hold);
      if (rnd && n > 0) raddr[d] = rnd_addr(set_idx($urandom_range(16, 0)));
      en[d] = e; wr[d] = w; waddr[d] = wa; be[d] = wb; wdata[d] = wv;
      @(posedge clk);
      if (e) begin
        if (n >= lat && !rd[d]) begin
          done = 1'b1;
        end else begin
          n++;
          if (n == lat) exp_d = mem_m[d][widx(a)];
        end
        if (w) model_write(d, wa, wb, wv);
      end
      #1;
      check_eq("ack", 32'(ack[d]), 32'(n == lat && !done));
      check_eq("busy", 32'(busy[d]), 32'(n > 0 && !done));
      if (n == lat && !done) begin
        check_eq("ack_data", rdat[d], exp_d);
        got = rdat[d];
      end
    end
    check_eq("read_done", 32'(done), 32'd1);
    rd[d] = 1'b0; wr[d] = 1'b0; en[d] = 1'b1;
    check_eq("data_hold", rdat[d], exp_d);
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      raddr[d] = '0; waddr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ack", 32'(ack[d]), 32'd0);
      check_eq("rst_busy", 32'(busy[d]), 32'd0);
      check_eq("rst_data", rdat[d], 32'd0);
    end
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k <= 16; k++) wr_word(d, set_idx(k) << 2, 4'hF, $urandom);
    end

    // Latency 1: store/load, byte enables, collision, wrap.
    wr_word(0, 32'h100, 4'hF, 32'hDEAD_BEEF);
    do_read(0, 32'h100, 1'b0, 1'b0, 1'b0, got);
    check_eq("store_load", got, 32'hDEAD_BEEF);
    wr_word(0, 32'h100, 4'b0010, 32'h0000_5500);
    do_read(0, 32'h102, 1'b0, 1'b0, 1'b0, got);
    check_eq("byte_en", got, 32'hDEAD_55EF);
    wr_word(0, 32'h40, 4'hF, 32'h1111_1111);
    do_read(0, 32'h40, 1'b0, 1'b1, 1'b0, got);
    check_eq("coll_old", got, 32'h1111_1111);
    do_read(0, 32'h40, 1'b0, 1'b0, 1'b0, got);
    check_eq("coll_new", got, 32'h2222_2222);
    wr_word(0, 32'h0, 4'hF, 32'hA5A5_0F0F);
    do_read(0, 32'h1000, 1'b0, 1'b0, 1'b0, got);
    check_eq("wrap", got, 32'hA5A5_0F0F);

    // Latency 3: plain hold, clock-enable stretching.
    do_read(1, 32'h100, 1'b0, 1'b0, 1'b0, got);
    do_read(1, 32'h100, 1'b1, 1'b0, 1'b0, got);

    // Reset two edges into a latency-3 read: no ack, RAM word kept.
    wr_word(1, 32'h200, 4'hF, 32'hCAFE_F00D);
    rd[1] = 1'b1; raddr[1] = 32'h200; en[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; rd[1] = 1'b0;
    check_eq("mid_rst_ack", 32'(ack[1]), 32'd0);
    check_eq("mid_rst_busy", 32'(busy[1]), 32'd0);
    check_eq("mid_rst_data", rdat[1], 32'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_eq("no_ack_after_rst", 32'(ack[1]), 32'd0);
    end
    do_read(1, 32'h200, 1'b0, 1'b0, 1'b0, got);
    check_eq("rst_preserved", got, 32'hCAFE_F00D);

    repeat (40) begin
      int d;
      d = $urandom_range(1, 0);
      do_read(d, rnd_addr(set_idx($urandom_range(16, 0))), 1'b1, $urandom_range(3, 0) == 0,
              $urandom_range(3, 0) == 0, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
